rom_boot_loader: RTL
====================

# rom_boot_loader

Hardware program loader for the SoC instruction ROM. It receives a framed byte stream from a UART receiver, packs the bytes little-endian into 32-bit words, and writes them through the ROM's write port starting at word 0. It holds the core in reset until a complete, valid image is loaded. At runtime it fills instruction memory in place of a simulation-time `$readmemh`.

## Interface
- ADDR_W, 12, ROM word-address width; image capacity is 2^ADDR_W words.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes inside a frame.
- SYNC_BYTE, 8'hA5, frame start marker.

- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- rx_valid  in  1  byte available from the UART receiver
- rx_data  in  8  received byte
- rx_ready  out  1  loader accepts a byte; 0 during reset, 1 otherwise
- rom_we  out  1  ROM write strobe, one-cycle pulse per word
- rom_waddr  out  ADDR_W  word address of the write
- rom_wdata  out  32  word to write
- cpu_hold  out  1  holds the core in reset while 1
- load_ok  out  1  sticky: last frame completed correctly
- load_err  out  1  sticky: last frame was aborted

## Operation
- A byte is accepted on a posedge where rx_valid && rx_ready.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI (word count N, 16 bits), 4·N data bytes, then CSUM. CSUM is the XOR of all data bytes.
- FSM states: IDLE, LEN0, LEN1, DATA, CSUM, DONE.
  - IDLE: wait for SYNC_BYTE; discard all other bytes.
  - SYNC_BYTE accepted in IDLE or DONE: go to LEN0. Set cpu_hold=1, clear load_ok and load_err, reset the word address and checksum.
  - LEN0 -> LEN1.
  - LEN1:
    - If N > 2^ADDR_W: set load_err and return to IDLE.
    - If N == 0: go to CSUM.
    - Otherwise: go to DATA.
  - DATA: byte k of a word lands in bits [8k+7:8k]. The 4th byte triggers a write. After the write of word N-1, go to CSUM.
  - CSUM:
    - If the byte equals the running XOR: go to DONE, set load_ok, set cpu_hold=0.
    - Otherwise: set load_err, go to IDLE, keep cpu_hold=1.
  - DONE: non-sync bytes are ignored; a sync byte starts a reload.
- Timeout: in LEN0, LEN1, DATA or CSUM, if no byte is accepted for TIMEOUT_CYCLES consecutive cycles, set load_err and go to IDLE. Any partially packed word is dropped and not written.
- Words already written by an aborted frame stay in the ROM. cpu_hold stays 1 after an abort.

## Timing
- Reset values: rx_ready=0, rom_we=0, rom_waddr=0, rom_wdata=0, cpu_hold=1, load_ok=0, load_err=0, state IDLE.
- rom_we, rom_waddr and rom_wdata are registered. rom_we pulses in the cycle after the 4th byte of a word is accepted. rom_waddr increments after each write.
- On success, cpu_hold deasserts, and load_ok asserts, in the cycle after CSUM is accepted. load_err asserts in the cycle after the abort condition.
- The loader never stalls: back-to-back bytes on every cycle are accepted.
- The timeout counter reloads on every accepted byte. Abort fires when the count reaches TIMEOUT_CYCLES.
- Reset mid-frame: all outputs return to their reset values the next cycle. The next frame loads from address 0.

## Configuration
- ROM_BOOT_LOADER_CHECKSUM_EN defined: the CSUM byte is present and checked as described above.
- ROM_BOOT_LOADER_CHECKSUM_EN not defined:
  - The frame has no CSUM byte and the CSUM state is removed.
  - After the last write, go directly to DONE (cpu_hold=0, load_ok=1) in the cycle after that write.
  - With N == 0, go to DONE from LEN1.

## Structure
- Package rom_boot_loader_pkg holds:
  - the state enum;
  - default constants for SYNC_BYTE and TIMEOUT_CYCLES;
  - a 32-bit word typedef.
- Sub-module boot_word_packer: byte counter and little-endian shift register. It outputs a word-valid pulse and clears on abort.

## Test plan
- Frame A5 02 00 13 00 00 00 93 00 10 00 90 -> writes addr0=0x00000013 and addr1=0x00100093; then cpu_hold=0 and load_ok=1.
- Same frame with CSUM 91 -> both words written, load_err=1, cpu_hold=1, state IDLE.
- Bytes 00 FF 5A before the sync byte -> no rom_we pulse and no flag change; the following valid frame loads normally.
- TIMEOUT_CYCLES=16, stall 16 cycles after 2 data bytes -> load_err=1, no write of the partial word; a new frame then succeeds.
- ADDR_W=12, length bytes 01 10 (N=0x1001) -> load_err=1 in the cycle after LEN_HI, no writes.
- rst asserted in the middle of DATA -> all outputs at reset values; the next frame writes starting at addr0.

Source files
------------

// File: rtl/rom_boot_loader_pkg.sv
// Shared types and defaults for the ROM boot loader.
// The CSUM state exists only when ROM_BOOT_LOADER_CHECKSUM_EN is defined.
package rom_boot_loader_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT      = 8'hA5;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1000000;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE
  } state_t;

endpackage

// File: rtl/rom_boot_loader_word_packer.sv
// Packs accepted data bytes little-endian into 32-bit words; pulses
// word_valid combinationally on the 4th byte and drops partial words on clear.
module boot_word_packer
  import rom_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [23:0] partial;
  word_t       packed_word;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt <= '0;
      partial  <= '0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      partial  <= {byte_data, partial[23:8]};
    end
  end

  // Earlier bytes have shifted down, so the newest byte lands on top.
  assign packed_word = {byte_data, partial};
  assign word_valid  = byte_valid && (byte_cnt == 2'd3);
  assign word        = packed_word;

endmodule

// File: rtl/rom_boot_loader.sv
// Framed UART byte stream -> instruction ROM writer; holds the CPU until a
// complete image is loaded. Define ROM_BOOT_LOADER_CHECKSUM_EN for the CSUM byte.
module rom_boot_loader
  import rom_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_hold,
  output logic              load_ok,
  output logic              load_err
);

  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER_DATA = ST_CSUM;
`else
  localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

  state_t      state, next_state;
  logic        accept, is_sync, active, timeout;
  logic [7:0]  len_lo;
  logic [16:0] len, len_in, word_cnt;
  logic [31:0] idle_cnt;
  logic        start, set_err, set_ok, ok_now, data_byte, last_word;
  logic        word_valid;
  logic [31:0] pack_word;
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
  logic        csum_match;
`else
  logic        finish, ok_pending;
`endif

  assign accept    = rx_valid && rx_ready;
  assign is_sync   = accept && (rx_data == SYNC_BYTE);
  assign len_in    = {1'b0, rx_data, len_lo};
  assign active    = (state != ST_IDLE) && (state != ST_DONE);
  assign timeout   = active && !accept && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign last_word = word_valid && (word_cnt == len - 17'd1);
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
  assign csum_match = (rx_data == csum);
  assign set_ok     = ok_now;
`else
  assign set_ok     = ok_now || ok_pending;
`endif

  boot_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start || set_err),
    .byte_valid (data_byte),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (pack_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (timeout) begin
      next_state = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: if (is_sync) next_state = ST_LEN0;
        ST_LEN0:          if (accept)  next_state = ST_LEN1;
        ST_LEN1: begin
          if (accept) begin
            if (len_in > CAPACITY)  next_state = ST_IDLE;
            else if (len_in == '0)  next_state = ST_AFTER_DATA;
            else                    next_state = ST_DATA;
          end
        end
        ST_DATA:          if (last_word) next_state = ST_AFTER_DATA;
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
        ST_CSUM:          if (accept) next_state = csum_match ? ST_DONE : ST_IDLE;
`endif
        default:          next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    start     = 1'b0;
    set_err   = timeout;
    ok_now    = 1'b0;
    data_byte = 1'b0;
`ifndef ROM_BOOT_LOADER_CHECKSUM_EN
    finish    = 1'b0;
`endif
    unique case (state)
      ST_IDLE, ST_DONE: start = is_sync;
      ST_LEN1: begin
        if (accept) begin
          if (len_in > CAPACITY) set_err = 1'b1;
`ifndef ROM_BOOT_LOADER_CHECKSUM_EN
          else if (len_in == '0) ok_now = 1'b1;
`endif
        end
      end
      ST_DATA: begin
        data_byte = accept;
`ifndef ROM_BOOT_LOADER_CHECKSUM_EN
        finish    = last_word;
`endif
      end
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) begin
          if (csum_match) ok_now  = 1'b1;
          else            set_err = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ready  <= 1'b0;
      rom_we    <= 1'b0;
      rom_waddr <= '0;
      rom_wdata <= '0;
      cpu_hold  <= 1'b1;
      load_ok   <= 1'b0;
      load_err  <= 1'b0;
      len_lo    <= '0;
      len       <= '0;
      word_cnt  <= '0;
      idle_cnt  <= '0;
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
      csum      <= '0;
`else
      ok_pending <= 1'b0;
`endif
    end else begin
      rx_ready <= 1'b1;
      rom_we   <= word_valid;
      if (rom_we)     rom_waddr <= rom_waddr + ADDR_W'(1);
      if (word_valid) begin
        rom_wdata <= pack_word;
        word_cnt  <= word_cnt + 17'd1;
      end
      if (accept && state == ST_LEN0) len_lo <= rx_data;
      if (accept && state == ST_LEN1) len    <= len_in;
      if (accept || !active) idle_cnt <= '0;
      else                   idle_cnt <= idle_cnt + 32'd1;
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
      if (data_byte) csum <= csum ^ rx_data;
`else
      // Success shows one cycle after the final write pulse.
      ok_pending <= finish;
`endif
      if (set_err) load_err <= 1'b1;
      if (set_ok) begin
        load_ok  <= 1'b1;
        cpu_hold <= 1'b0;
      end
      // A reload that begins in the same cycle overrides a pending success.
      if (start) begin
        rom_waddr <= '0;
        word_cnt  <= '0;
        cpu_hold  <= 1'b1;
        load_ok   <= 1'b0;
        load_err  <= 1'b0;
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
        csum      <= '0;
`endif
      end
    end
  end

endmodule
